// File: rtl/ahb_slave_ctrl_if.sv
// rtl/ahb_slave_ctrl_if.sv - AHB-Lite slave-side bus signal bundle
interface ahb_slave_ctrl_if;
    logic        HSELx;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSELx, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSELx, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_slave_ctrl.sv
// rtl/ahb_slave_ctrl.sv - AHB-Lite data-phase controller with outbound write FIFO
module ahb_slave_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'hF0F0F0F0,
    parameter int          FIFO_DEPTH = 4,
    parameter int          READ_WAIT  = 1
) (
    input  logic                        clk,
    input  logic                        n_rst,
    ahb_slave_ctrl_if.slave             ahb,
    input  logic [31:0]                 rd_data,
    output logic                        fifo_valid,
    output logic [31:0]                 fifo_data,
    input  logic                        fifo_pop,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam int         CW        = AW + 1;
    localparam logic [3:0] WAIT_LOAD = 4'(READ_WAIT);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD_WAIT, S_RD_LAST, S_ERR1, S_ERR2
    } state_t;

    state_t          state_q, state_d, acc_state;
    logic [3:0]      cnt_q, cnt_d;
    logic            offset_q, offset_d;
    logic [31:0]     hrdata_q, hrdata_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [31:0]     mem_d [FIFO_DEPTH];

    logic            full, empty, accept, legal, push, pop, load_addr;
    logic            hreadyout, hresp;
    logic [31:0]     status_word;
    logic            unused_htrans0;

    assign unused_htrans0 = ahb.HTRANS[0];

    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign status_word = {27'b0, full, empty, 3'(count_q)};
    assign accept      = ahb.HSELx & ahb.HREADY & ahb.HTRANS[1];
    assign legal       = (ahb.HSIZE == 3'b010) && (ahb.HADDR[1:0] == 2'b00) &&
                         (ahb.HADDR[31:3] == BASE_ADDR[31:3]) &&
                         !(ahb.HWRITE && ahb.HADDR[2]);
    assign pop         = fifo_pop & ~empty;

    assign ahb.HREADYOUT = hreadyout;
    assign ahb.HRESP     = hresp;
    assign ahb.HRDATA    = hrdata_q;
    assign fifo_valid    = ~empty;
    assign fifo_data     = mem_q[rd_ptr_q];
    assign fifo_count    = count_q;

    always_comb begin
        acc_state = S_ERR1;
        if (legal) begin
            if (ahb.HWRITE)                       acc_state = S_WR;
            else if (!ahb.HADDR[2] && READ_WAIT > 0) acc_state = S_RD_WAIT;
            else                                  acc_state = S_RD_LAST;
        end

        state_d   = state_q;
        cnt_d     = cnt_q;
        offset_d  = offset_q;
        hrdata_d  = hrdata_q;
        push      = 1'b0;
        load_addr = 1'b0;
        hreadyout = 1'b1;
        hresp     = 1'b0;

        case (state_q)
            S_IDLE: load_addr = 1'b1;
            S_WR: begin
                // full is registered, so a same-cycle pop cannot release a stalled push
                hreadyout = ~full;
                if (!full) begin
                    push      = 1'b1;
                    load_addr = 1'b1;
                end
            end
            S_RD_WAIT: begin
                hreadyout = 1'b0;
                if (cnt_q <= 4'd1) begin
                    state_d  = S_RD_LAST;
                    hrdata_d = offset_q ? status_word : rd_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RD_LAST: load_addr = 1'b1;
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                hresp     = 1'b1;
                load_addr = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (load_addr) begin
            state_d = accept ? acc_state : S_IDLE;
            if (accept) begin
                offset_d = ahb.HADDR[2];
                if (acc_state == S_RD_WAIT) cnt_d = WAIT_LOAD;
                if (acc_state == S_RD_LAST) hrdata_d = ahb.HADDR[2] ? status_word : rd_data;
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = ahb.HWDATA;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            offset_q <= 1'b0;
            hrdata_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
            hrdata_q <= hrdata_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end
endmodule
